// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding, the opcodes handled by
// the IO sequencer, the decoded-opcode flags and the registered strobe bundle.
// Reused by the full control unit, so keep encodings stable.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StRst  = 3'd0,
        StT0   = 3'd1,
        StT1   = 3'd2,
        StT2   = 3'd3,
        StT3   = 3'd4,
        StHalt = 3'd5
    } ctrl_state_e;

    localparam logic [4:0] OpIn   = 5'b10101;
    localparam logic [4:0] OpOut  = 5'b10110;
    localparam logic [4:0] OpMfhi = 5'b10111;
    localparam logic [4:0] OpMflo = 5'b11000;
    localparam logic [4:0] OpNop  = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11010;

    typedef struct packed {
        logic is_in;
        logic is_out;
        logic is_mfhi;
        logic is_mflo;
        logic is_nop;
        logic is_halt;
        logic is_illegal;
    } op_dec_t;

    typedef struct packed {
        logic pc_out;
        logic mar_enable;
        logic inc_pc;
        logic zlow_in;
        logic zlow_out;
        logic pc_enable;
        logic mdr_read;
        logic mdr_enable;
        logic mdr_out;
        logic ir_enable;
        logic gra;
        logic r_in;
        logic r_out;
        logic inport_out;
        logic outport_enable;
        logic hi_out;
        logic lo_out;
        logic run;
    } ctrl_out_t;

endpackage

// File: rtl/io_op_decode.sv
// Combinational opcode classifier for the IO sequencer.
//   op_i  : 5-bit opcode field IR[31:27]
//   dec_o : one flag per supported opcode, plus is_illegal for anything else
module io_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] op_i,
    output op_dec_t    dec_o
);

    always_comb begin
        dec_o = '0;
        case (op_i)
            OpIn:    dec_o.is_in      = 1'b1;
            OpOut:   dec_o.is_out     = 1'b1;
            OpMfhi:  dec_o.is_mfhi    = 1'b1;
            OpMflo:  dec_o.is_mflo    = 1'b1;
            OpNop:   dec_o.is_nop     = 1'b1;
            OpHalt:  dec_o.is_halt    = 1'b1;
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/io_sequencer.sv
// Fetch/execute sequencer for the IO-class instructions (in, out, mfhi, mflo, nop, halt).
//   Clock, Clear      : system clock, asynchronous active-high reset
//   IR_op             : opcode IR[31:27], sampled on entry to T3
//   MemReady          : memory read data valid, releases the T1 wait
//   Stop              : halt request, honoured only when leaving T3
//   T0..T3 strobes    : datapath control, all registered
//   Run               : 1 while fetching/executing
//   Illegal           : sticky unsupported-opcode flag
// Outputs are decoded from the *next* state and registered with it, so they line up with
// the state they describe while having no combinational path from any input.
module io_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] IR_op,
    input  logic       MemReady,
    input  logic       Stop,
    output logic       PCout,
    output logic       MAR_enable,
    output logic       IncPC,
    output logic       ZLowIn,
    output logic       ZLowout,
    output logic       PC_enable,
    output logic       MDR_read,
    output logic       MDR_enable,
    output logic       MDRout,
    output logic       IR_enable,
    output logic       Gra,
    output logic       R_in,
    output logic       R_out,
    output logic       InPortout,
    output logic       OutPort_enable,
    output logic       HIout,
    output logic       LOout,
    output logic       Run,
    output logic       Illegal
);

    ctrl_state_e state_q, state_d;
    op_dec_t     dec_ir;
    op_dec_t     op_q, op_d;
    ctrl_out_t   out_q, out_d;
    logic        illegal_q, illegal_d;

    io_op_decode u_op_decode (
        .op_i  (IR_op),
        .dec_o (dec_ir)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (MemReady) state_d = StT2;
            StT2: begin
                // IR is loaded at the end of T2, so IR_op is valid at this edge.
                state_d = StT3;
                op_d    = dec_ir;
            end
            StT3: begin
                if (op_q.is_halt || op_q.is_illegal || Stop) state_d = StHalt;
                else                                          state_d = StT0;
            end
            default: state_d = StHalt;
        endcase
        illegal_d = illegal_q || ((state_d == StT3) && op_d.is_illegal);
    end

    always_comb begin
        out_d = '0;
        case (state_d)
            StT0: begin
                out_d.run        = 1'b1;
                out_d.pc_out     = 1'b1;
                out_d.mar_enable = 1'b1;
                out_d.inc_pc     = 1'b1;
                out_d.zlow_in    = 1'b1;
            end
            StT1: begin
                out_d.run        = 1'b1;
                out_d.zlow_out   = 1'b1;
                out_d.pc_enable  = 1'b1;
                out_d.mdr_read   = 1'b1;
                out_d.mdr_enable = 1'b1;
            end
            StT2: begin
                out_d.run       = 1'b1;
                out_d.mdr_out   = 1'b1;
                out_d.ir_enable = 1'b1;
            end
            StT3: begin
                out_d.run            = 1'b1;
                // Every decoded opcode other than nop/halt/illegal touches the register file.
                out_d.gra            = !(op_d.is_nop || op_d.is_halt || op_d.is_illegal);
                out_d.r_in           = op_d.is_in || op_d.is_mfhi || op_d.is_mflo;
                out_d.r_out          = op_d.is_out;
                out_d.inport_out     = op_d.is_in;
                out_d.outport_enable = op_d.is_out;
                out_d.hi_out         = op_d.is_mfhi;
                out_d.lo_out         = op_d.is_mflo;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q   <= StRst;
            op_q      <= '0;
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            out_q     <= out_d;
            illegal_q <= illegal_d;
        end
    end

    assign PCout          = out_q.pc_out;
    assign MAR_enable     = out_q.mar_enable;
    assign IncPC          = out_q.inc_pc;
    assign ZLowIn         = out_q.zlow_in;
    assign ZLowout        = out_q.zlow_out;
    assign PC_enable      = out_q.pc_enable;
    assign MDR_read       = out_q.mdr_read;
    assign MDR_enable     = out_q.mdr_enable;
    assign MDRout         = out_q.mdr_out;
    assign IR_enable      = out_q.ir_enable;
    assign Gra            = out_q.gra;
    assign R_in           = out_q.r_in;
    assign R_out          = out_q.r_out;
    assign InPortout      = out_q.inport_out;
    assign OutPort_enable = out_q.outport_enable;
    assign HIout          = out_q.hi_out;
    assign LOout          = out_q.lo_out;
    assign Run            = out_q.run;
    assign Illegal        = illegal_q;

endmodule

// File: doc/io_sequencer.md
IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Clock  in  1  single system clock; all state changes on posedge Clock.
REQ-002 Clear  in  1  asynchronous, active-high reset.
REQ-003 IR_op  in  5  opcode field IR[31:27] from the datapath IR register.
REQ-004 MemReady  in  1  memory read data valid; 1 = Mdatain usable this cycle.
REQ-005 Stop  in  1  halt request, honoured only at an instruction boundary.
REQ-006 PCout, MAR_enable, IncPC, ZLowIn  out  1 each  T0 fetch strobes.
REQ-007 ZLowout, PC_enable, MDR_read, MDR_enable  out  1 each  T1 strobes.
REQ-008 MDRout, IR_enable  out  1 each  T2 strobes.
REQ-009 Gra, R_in, R_out  out  1 each  register-file select/enable.
REQ-010 InPortout, OutPort_enable, HIout, LOout  out  1 each  T3 execute strobes.
REQ-011 Run  out  1  1 while fetching/executing; 0 in RST and HALT.
REQ-012 Illegal  out  1  sticky; set on an unsupported opcode.

Function
REQ-013 States: RST, T0, T1, T2, T3, HALT; one state per cycle except T1 waits.
REQ-014 All outputs are registered Moore decodes of the state (T3 also of the latched opcode); no combinational path from any input to any output.
REQ-015 RST -> T0 unconditionally on the first posedge after Clear falls.
REQ-016 T0: PCout=MAR_enable=IncPC=ZLowIn=1; next T1.
REQ-017 T1: ZLowout=PC_enable=MDR_read=MDR_enable=1; remain in T1 while MemReady=0 (repeated PC load from unchanged Z is idempotent); next T2 when MemReady=1.
REQ-018 T2: MDRout=IR_enable=1; next T3.
REQ-019 Opcode is sampled from IR_op on entry to T3 (IR loaded at end of T2) and held in an internal register.
REQ-020 T3 in (10101): Gra=R_in=InPortout=1.
REQ-021 T3 out (10110): Gra=R_out=OutPort_enable=1.
REQ-022 T3 mfhi (10111): Gra=R_in=HIout=1; mflo (11000): Gra=R_in=LOout=1.
REQ-023 T3 nop (11001): no strobes; halt (11010): no strobes, next HALT.
REQ-024 T3 any other opcode: no strobes, Illegal set to 1, next HALT.
REQ-025 Leaving T3: next T0, unless halt opcode, illegal opcode, or Stop=1 sampled in T3, each giving HALT.
REQ-026 Stop in T0-T2 is ignored; the current instruction always completes.
REQ-027 HALT: all strobes 0, Run=0; exit only via Clear.
REQ-028 Never more than one of InPortout, HIout, LOout, ZLowout, MDRout, PCout high in the same cycle (single bus driver).

Reset
REQ-029 Clear=1 forces state RST and every output to 0 (including Illegal and Run) immediately, independent of Clock, including mid-instruction or during a T1 wait.

Structure
REQ-030 Opcode constants (in, out, mfhi, mflo, nop, halt) and state encoding live in shared package cpu_ctrl_pkg, reused by the full control unit.
REQ-031 One sub-module, io_op_decode: combinational 5-bit opcode -> {is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt, is_illegal}.

Verification
REQ-032 Clear 1->0, MemReady=1, IR_op=10101: cycle1 T0 strobes, cycle2 T1, cycle3 T2, cycle4 Gra=R_in=InPortout=1, cycle5 T0 again.
REQ-033 IR_op=10110, MemReady low for 3 cycles: T1 strobes held 4 cycles, then T2; T3 asserts Gra=R_out=OutPort_enable only.
REQ-034 IR_op=11010: after T3, HALT with Run=0 held for 20 cycles; Clear pulse restarts at T0.
REQ-035 IR_op=00011 (unsupported): T3 has no strobes, Illegal=1 and HALT next; Illegal stays 1 until Clear.
REQ-036 Stop=1 during T1 of a nop: instruction completes through T3 and then HALT; Clear asserted mid-T2 drops all outputs within the same cycle.
